// File: rtl/branch_resolve_queue.sv
// In-order queue of unresolved branches/jumps: operands wake up from the CDB,
// the head resolves when ready, and a taken resolution redirects fetch and squashes the queue.
module brq_entry #(
  parameter int RSID_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  pop,
  input  logic                  wr_en,
  input  logic [2:0]            wr_cond,
  input  logic [31:0]           wr_target,
  input  logic                  wr_op1_ready,
  input  logic [RSID_WIDTH-1:0] wr_op1_rsid,
  input  logic [31:0]           wr_op1_data,
  input  logic                  wr_op2_ready,
  input  logic [RSID_WIDTH-1:0] wr_op2_rsid,
  input  logic [31:0]           wr_op2_data,
  input  logic                  cdb_valid,
  input  logic [RSID_WIDTH-1:0] cdb_rsid,
  input  logic [31:0]           cdb_data,
  output logic                  vld,
  output logic [2:0]            cond,
  output logic [31:0]           target,
  output logic                  op1_ready,
  output logic [31:0]           op1_data,
  output logic                  op2_ready,
  output logic [31:0]           op2_data
);
  logic                  vld_q, vld_d;
  logic [2:0]            cond_q, cond_d;
  logic [31:0]           target_q, target_d;
  logic                  op1_ready_q, op1_ready_d, op2_ready_q, op2_ready_d;
  logic [RSID_WIDTH-1:0] op1_rsid_q, op1_rsid_d, op2_rsid_q, op2_rsid_d;
  logic [31:0]           op1_data_q, op1_data_d, op2_data_q, op2_data_d;

  always_comb begin
    vld_d       = vld_q;
    cond_d      = cond_q;
    target_d    = target_q;
    op1_ready_d = op1_ready_q;
    op1_rsid_d  = op1_rsid_q;
    op1_data_d  = op1_data_q;
    op2_ready_d = op2_ready_q;
    op2_rsid_d  = op2_rsid_q;
    op2_data_d  = op2_data_q;
    if (vld_q && cdb_valid) begin
      if (!op1_ready_q && cdb_rsid == op1_rsid_q) begin
        op1_ready_d = 1'b1;
        op1_data_d  = cdb_data;
      end
      if (!op2_ready_q && cdb_rsid == op2_rsid_q) begin
        op2_ready_d = 1'b1;
        op2_data_d  = cdb_data;
      end
    end
    if (pop) vld_d = 1'b0;
    if (wr_en) begin
      vld_d       = 1'b1;
      cond_d      = wr_cond;
      target_d    = wr_target;
      op1_ready_d = wr_op1_ready;
      op1_rsid_d  = wr_op1_rsid;
      op1_data_d  = wr_op1_data;
      op2_ready_d = wr_op2_ready;
      op2_rsid_d  = wr_op2_rsid;
      op2_data_d  = wr_op2_data;
    end
    if (clr) vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= 1'b0;
      cond_q      <= '0;
      target_q    <= '0;
      op1_ready_q <= 1'b0;
      op1_rsid_q  <= '0;
      op1_data_q  <= '0;
      op2_ready_q <= 1'b0;
      op2_rsid_q  <= '0;
      op2_data_q  <= '0;
    end else begin
      vld_q       <= vld_d;
      cond_q      <= cond_d;
      target_q    <= target_d;
      op1_ready_q <= op1_ready_d;
      op1_rsid_q  <= op1_rsid_d;
      op1_data_q  <= op1_data_d;
      op2_ready_q <= op2_ready_d;
      op2_rsid_q  <= op2_rsid_d;
      op2_data_q  <= op2_data_d;
    end
  end

  assign vld       = vld_q;
  assign cond      = cond_q;
  assign target    = target_q;
  assign op1_ready = op1_ready_q;
  assign op1_data  = op1_data_q;
  assign op2_ready = op2_ready_q;
  assign op2_data  = op2_data_q;
endmodule

module branch_resolve_queue #(
  parameter int DEPTH      = 4,
  parameter int RSID_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [2:0]            push_cond,
  input  logic [31:0]           push_target,
  input  logic [31:0]           push_fallthrough,
  input  logic                  push_op1_ready,
  input  logic                  push_op2_ready,
  input  logic [RSID_WIDTH-1:0] push_op1_rsid,
  input  logic [RSID_WIDTH-1:0] push_op2_rsid,
  input  logic [31:0]           push_op1_data,
  input  logic [31:0]           push_op2_data,
  input  logic                  cdb_valid,
  input  logic [RSID_WIDTH-1:0] cdb_rsid,
  input  logic [31:0]           cdb_data,
  input  logic                  flush,
  output logic                  resolve_valid,
  output logic                  resolve_taken,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          resolve_valid_q, resolve_valid_d, resolve_taken_q, resolve_taken_d;
  logic          redirect_valid_q, redirect_valid_d, busy_q, busy_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;

  logic [DEPTH-1:0]        e_vld, e_op1_ready, e_op2_ready, e_wr, e_pop;
  logic [DEPTH-1:0][2:0]   e_cond;
  logic [DEPTH-1:0][31:0]  e_target, e_op1, e_op2;

  // Fall-through is not needed: fetch already went down the not-taken path.
  logic unused_fallthrough;
  assign unused_fallthrough = ^push_fallthrough;

  logic        push_fire, op2_ign, op1_byp, op2_byp;
  logic        wr_op1_ready, wr_op2_ready;
  logic [31:0] wr_op1_data, wr_op2_data;

  assign push_ready = (count_q < CW'(DEPTH));
  assign push_fire  = push_valid && push_ready;
  assign op2_ign    = (push_cond >= 3'd2) && (push_cond <= 3'd6);
  assign op1_byp    = !push_op1_ready && cdb_valid && (cdb_rsid == push_op1_rsid);
  assign op2_byp    = !push_op2_ready && cdb_valid && (cdb_rsid == push_op2_rsid);
  assign wr_op1_ready = push_op1_ready || op1_byp;
  assign wr_op2_ready = push_op2_ready || op2_byp || op2_ign;
  assign wr_op1_data  = push_op1_ready ? push_op1_data : cdb_data;
  assign wr_op2_data  = push_op2_ready ? push_op2_data : cdb_data;

  logic        h_vld, h_rdy, h_taken, pop, redir, clr_all;
  logic [2:0]  h_cond;
  logic [31:0] h_op1, h_op2, h_target;

  assign h_vld    = e_vld[head_q];
  assign h_cond   = e_cond[head_q];
  assign h_op1    = e_op1[head_q];
  assign h_op2    = e_op2[head_q];
  assign h_target = e_target[head_q];
  assign h_rdy    = h_vld && e_op1_ready[head_q] && e_op2_ready[head_q];

  always_comb begin
    h_taken = 1'b0;
    case (h_cond)
      3'd0: h_taken = (h_op1 == h_op2);
      3'd1: h_taken = (h_op1 != h_op2);
      3'd2: h_taken = !h_op1[31] && (|h_op1);
      3'd3: h_taken = h_op1[31] || (h_op1 == '0);
      3'd4: h_taken = h_op1[31];
      3'd5: h_taken = !h_op1[31];
      3'd6: h_taken = 1'b1;
      default: h_taken = 1'b0;
    endcase
  end

  assign pop     = h_rdy && !flush;
  assign redir   = pop && h_taken;
  assign clr_all = flush || redir;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign e_wr[gi]  = push_fire && !clr_all && (tail_q == PW'(gi));
      assign e_pop[gi] = pop && (head_q == PW'(gi));
      brq_entry #(.RSID_WIDTH(RSID_WIDTH)) u_ent (
        .clk(clk), .rst(rst), .clr(clr_all), .pop(e_pop[gi]), .wr_en(e_wr[gi]),
        .wr_cond(push_cond), .wr_target(push_target),
        .wr_op1_ready(wr_op1_ready), .wr_op1_rsid(push_op1_rsid), .wr_op1_data(wr_op1_data),
        .wr_op2_ready(wr_op2_ready), .wr_op2_rsid(push_op2_rsid), .wr_op2_data(wr_op2_data),
        .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
        .vld(e_vld[gi]), .cond(e_cond[gi]), .target(e_target[gi]),
        .op1_ready(e_op1_ready[gi]), .op1_data(e_op1[gi]),
        .op2_ready(e_op2_ready[gi]), .op2_data(e_op2[gi])
      );
    end
  endgenerate

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push_fire);
    count_d = count_q + CW'(push_fire) - CW'(pop);
    if (clr_all) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    busy_d           = (count_d != '0);
    resolve_valid_d  = pop;
    resolve_taken_d  = redir;
    redirect_valid_d = redir;
    redirect_pc_d    = '0;
    if (redir) redirect_pc_d = (h_cond == 3'd6) ? h_op1 : h_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      busy_q           <= 1'b0;
      resolve_valid_q  <= 1'b0;
      resolve_taken_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      busy_q           <= busy_d;
      resolve_valid_q  <= resolve_valid_d;
      resolve_taken_q  <= resolve_taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign resolve_valid  = resolve_valid_q;
  assign resolve_taken  = resolve_taken_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: expected outcomes queued at push,
// checked against each resolve pulse.
module tb_branch_resolve_queue;
  logic        clk, rst;
  logic        push_valid, push_ready;
  logic [2:0]  push_cond;
  logic [31:0] push_target, push_fallthrough;
  logic        push_op1_ready, push_op2_ready;
  logic [3:0]  push_op1_rsid, push_op2_rsid;
  logic [31:0] push_op1_data, push_op2_data;
  logic        cdb_valid;
  logic [3:0]  cdb_rsid;
  logic [31:0] cdb_data;
  logic        flush, resolve_valid, resolve_taken, redirect_valid, busy;
  logic [31:0] redirect_pc;

  branch_resolve_queue #(.DEPTH(4), .RSID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .push_cond(push_cond), .push_target(push_target), .push_fallthrough(push_fallthrough),
    .push_op1_ready(push_op1_ready), .push_op2_ready(push_op2_ready),
    .push_op1_rsid(push_op1_rsid), .push_op2_rsid(push_op2_rsid),
    .push_op1_data(push_op1_data), .push_op2_data(push_op2_data),
    .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data), .flush(flush),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic taken; logic [31:0] pc; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0, n_res = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  function automatic logic model_taken(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) > 0;
      3'd3: return $signed(a) <= 0;
      3'd4: return $signed(a) < 0;
      3'd5: return $signed(a) >= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // f1/f2 are the values the operands will finally hold (directly or via CDB)
  task automatic push_br(input logic [2:0] c, input logic [31:0] tgt,
                         input logic r1, input logic [3:0] s1, input logic [31:0] f1,
                         input logic r2, input logic [3:0] s2, input logic [31:0] f2);
    int w = 0;
    exp_t e;
    push_valid = 1'b1; push_cond = c; push_target = tgt; push_fallthrough = tgt ^ 32'h55;
    push_op1_ready = r1; push_op1_rsid = s1; push_op1_data = r1 ? f1 : $urandom;
    push_op2_ready = r2; push_op2_rsid = s2; push_op2_data = r2 ? f2 : $urandom;
    while (!push_ready && w < 60) begin @(negedge clk); w++; end
    if (!push_ready) begin
      chk("push_timeout", push_ready, 1);
      push_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.taken = model_taken(c, f1, f2);
    e.pc    = (c == 3'd6) ? f1 : tgt;
    sb.push_back(e);
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] id, input logic [31:0] d);
    @(negedge clk);
    cdb_valid = 1'b1; cdb_rsid = id; cdb_data = d;
    @(negedge clk);
    cdb_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
    chk("drain", sb.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (resolve_valid) begin
      n_res++;
      if (sb.size() == 0) chk("unexp_resolve", resolve_valid, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("taken", resolve_taken, e.taken);
        chk("redir_v", redirect_valid, e.taken);
        if (e.taken) begin
          chk("redir_pc", redirect_pc, e.pc);
          sb.delete();
        end
      end
    end else if (redirect_valid) chk("stray_redir", redirect_valid, 0);
  end

  logic [2:0]  tc [9] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd1, 3'd7, 3'd0};
  logic [31:0] ta [9] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h5, 32'h1, 32'h0, 32'h3, 32'h9, 32'h1};
  logic [31:0] tb [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'h9, 32'h2};

  initial begin
    int snap;
    rst = 1'b1; push_valid = 0; push_cond = 0; push_target = 0; push_fallthrough = 0;
    push_op1_ready = 0; push_op2_ready = 0; push_op1_rsid = 0; push_op2_rsid = 0;
    push_op1_data = 0; push_op2_data = 0; cdb_valid = 0; cdb_rsid = 0; cdb_data = 0; flush = 0;
    repeat (2) @(negedge clk);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resolve_valid", resolve_valid, 0);
    chk("rst_resolve_taken", resolve_taken, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    rst = 1'b0;
    @(negedge clk);

    // BEQ ready 5==5: resolves the edge after the push
    push_br(3'd0, 32'h400, 1, 0, 5, 1, 0, 5);
    chk("beq_busy", busy, 1);
    @(posedge clk); #2;
    chk("beq_lat_rv", resolve_valid, 1);
    chk("beq_lat_pc", redirect_pc, 32'h400);
    wait_drain();

    // BNE waiting on rsid 3
    push_br(3'd1, 32'h500, 0, 3, 7, 1, 0, 7);
    snap = n_res;
    repeat (3) @(negedge clk);
    chk("bne_wait", n_res, snap);
    chk("bne_busy", busy, 1);
    cdb(4'd3, 7);
    wait_drain();
    chk("bne_res", n_res, snap + 1);

    // fill, hold a fifth push, release by CDB
    push_br(3'd0, 32'h600, 0, 1, 1, 1, 0, 0);
    push_br(3'd0, 32'h604, 0, 2, 1, 1, 0, 0);
    push_br(3'd0, 32'h608, 0, 3, 1, 1, 0, 0);
    push_br(3'd0, 32'h60C, 0, 4, 1, 1, 0, 0);
    chk("full_ready", push_ready, 0);
    fork
      push_br(3'd4, 32'h1234, 1, 0, 32'h80000000, 1, 0, 0);
      begin
        repeat (2) @(negedge clk);
        chk("full_hold", push_ready, 0);
        chk("full_qlen", sb.size(), 4);
        cdb(4'd1, 1);
        cdb(4'd2, 1);
        cdb(4'd3, 1);
        cdb(4'd4, 1);
      end
    join
    wait_drain();
    chk("wrap_busy", busy, 0);

    // taken head squashes younger entry
    push_br(3'd2, 32'h2000, 0, 6, 1, 1, 0, 0);
    push_br(3'd0, 32'h2100, 0, 7, 0, 1, 0, 0);
    cdb(4'd6, 1);
    wait_drain();
    chk("squash_busy", busy, 0);
    snap = n_res;
    cdb(4'd7, 0);
    repeat (4) @(negedge clk);
    chk("squash_nores", n_res, snap);

    // JR with same-cycle CDB bypass
    cdb_valid = 1'b1; cdb_rsid = 4'd2; cdb_data = 32'h80001000;
    push_br(3'd6, 32'hDEAD0000, 0, 2, 32'h80001000, 0, 9, 0);
    cdb_valid = 1'b0;
    wait_drain();

    for (int i = 0; i < 9; i++) begin
      push_br(tc[i], 32'h3000 + 32'(i * 4), 1, 0, ta[i], 1, 0, tb[i]);
      wait_drain();
    end

    // flush, then reset, with three stuck entries
    for (int k = 0; k < 2; k++) begin
      push_br(3'd0, 32'h700, 0, 9, 0, 1, 0, 0);
      push_br(3'd0, 32'h704, 0, 9, 0, 1, 0, 0);
      push_br(3'd0, 32'h708, 0, 9, 0, 1, 0, 0);
      chk("pre_clr_busy", busy, 1);
      if (k == 0) flush = 1'b1; else rst = 1'b1;
      @(negedge clk);
      flush = 1'b0; rst = 1'b0;
      sb.delete();
      chk("clr_busy", busy, 0);
      chk("clr_push_ready", push_ready, 1);
      snap = n_res;
      cdb(4'd9, 0);
      repeat (4) @(negedge clk);
      chk("clr_nores", n_res, snap);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
